ifid_queue: RTL and testbench
=============================

// Module: ifid_queue
// PURPOSE
//  Fetch-to-decode instruction queue; sits between the fetch stage and the decode stage of the 5-stage CPU.
//  Buffers {instruction, PC+4} pairs so fetch keeps running while decode stalls.
//  Drops all in-flight entries on a flush (mispredicted branch) so decode never sees wrong-path instructions.
// PARAMETERS
//  N      32  datapath width (instruction and PC)
//  DEPTH  2   queue entries; power of two, >=2
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      fetch presents a valid entry
//  in_ready    out  1      queue accepts an entry this cycle
//  in_instr    in   N      fetched instruction
//  in_pcinc4   in   N      PC+4 of the fetched instruction
//  flush       in   1      discard all entries (branch misprediction from decode)
//  out_valid   out  1      head entry valid for decode
//  out_ready   in   1      decode consumes the head this cycle
//  out_instr   out  N      head instruction; NOP when out_valid=0
//  out_pcinc4  out  N      head PC+4; 0 when out_valid=0
//  stall_cnt   out  16     decode-stall cycle count (IFID_STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): count=0, rd/wr ptr=0, out_valid=0, in_ready=1, out_instr=NOP, out_pcinc4=0, stall_cnt=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH); registered-state only, no combinational path from out_ready.
//  - out_valid = (count != 0); outputs driven from storage[rd_ptr], masked to NOP/0 when empty.
//  - Latency: entry pushed in cycle t is visible at output in cycle t+1 (empty queue); no bypass.
//  - Push and pop in the same cycle: count unchanged, both pointers advance. Allowed at any non-empty, non-full count.
//  - Full: in_ready=0; a pop that cycle does not enable a same-cycle push. in_ready rises the next cycle.
//  - Empty: pop impossible (out_valid=0); out_ready ignored.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is $clog2(DEPTH+1) bits.
//  - flush=1: at the next edge count=0 and ptrs=0. Same-cycle push and pop are both discarded.
//    in_ready is unaffected by flush in the flush cycle. out_valid=0 in the cycle after the flush.
//  - Priority: rst > flush > push/pop.
//  - No state machine beyond count. Storage contents are not cleared on flush or reset; masked by count.
// CONFIGURATION
//  IFID_STALL_CNT_EN defined:
//    stall_cnt increments each cycle with out_valid=1 and out_ready=0; saturates at 16'hFFFF.
//    Cleared by rst only; flush does not clear it.
//  IFID_STALL_CNT_EN undefined:
//    stall_cnt port still present, tied to 16'h0; no counter flops.
// STRUCTURE
//  Package cpu_pkg:
//    - NOP constant (32'h0000_0000)
//    - typedef struct packed {logic [N-1:0] instr; logic [N-1:0] pcinc4;} ifid_entry_t
//  Storage array, pointers and count live inline.
//  One sub-module, ifid_stall_ctr: the saturating 16-bit counter, instantiated only under IFID_STALL_CNT_EN.
// TESTING
//  1. rst=1 for 2 cycles, then release -> out_valid=0, in_ready=1, out_instr=0, stall_cnt=0.
//  2. push {32'h0042_0013, 32'h4}, out_ready=1 -> next cycle out_valid=1, out_instr=32'h0042_0013;
//     the cycle after that, out_valid=0.
//  3. out_ready=0, push A,B -> in_ready=0 after B. Push C is held off.
//     Release out_ready -> A, then B, then C in order; no loss or duplication.
//  4. Queue holds 1 entry; push and pop in the same cycle for 10 cycles -> count stays 1;
//     pointers wrap; output order matches input order.
//  5. Queue full, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0;
//     the flushed-cycle input is never emitted.
//  6. IFID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5.
//     Force 16'hFFFE plus 3 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch/decode boundary.
package cpu_pkg;

  localparam int unsigned N = 32;

  localparam logic [N-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pcinc4;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_stall_ctr.sv
// Saturating 16-bit counter of decode-stall cycles.
module ifid_stall_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ifid_queue.sv
// Fetch-to-decode instruction queue with flush; all outputs come from flops.
// Optional stall counter enabled by defining IFID_STALL_CNT_EN.
module ifid_queue
  import cpu_pkg::ifid_entry_t, cpu_pkg::NOP;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_instr,
  input  logic [N-1:0] in_pcinc4,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pcinc4,
  output logic [15:0]  stall_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ifid_entry_t storage_q [DEPTH];
  ifid_entry_t storage_d [DEPTH];
  ifid_entry_t head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [N-1:0]     out_instr_q, out_instr_d;
  logic [N-1:0]     out_pcinc4_q, out_pcinc4_d;
  logic             push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next queue state; output flops are loaded from the post-update head.
  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        storage_d[wr_ptr_q].instr  = in_instr;
        storage_d[wr_ptr_q].pcinc4 = in_pcinc4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
    head         = storage_d[rd_ptr_d];
    out_valid_d  = (count_d != '0);
    in_ready_d   = (count_d != CNT_W'(DEPTH));
    out_instr_d  = out_valid_d ? head.instr  : NOP;
    out_pcinc4_d = out_valid_d ? head.pcinc4 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      out_instr_q  <= NOP;
      out_pcinc4_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      out_instr_q  <= out_instr_d;
      out_pcinc4_q <= out_pcinc4_d;
    end
  end

  // Payload storage is never cleared; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

  assign out_valid  = out_valid_q;
  assign in_ready   = in_ready_q;
  assign out_instr  = out_instr_q;
  assign out_pcinc4 = out_pcinc4_q;

`ifdef IFID_STALL_CNT_EN
  ifid_stall_ctr u_stall_ctr (
    .clk (clk),
    .rst (rst),
    .inc (out_valid_q & ~out_ready),
    .cnt (stall_cnt)
  );
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// Directed self-checking bench for ifid_queue.
module tb_ifid_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pcinc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pcinc4;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifid_queue #(.N(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pcinc4  (in_pcinc4),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pcinc4 (out_pcinc4),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid  = v;
    in_instr  = ins;
    in_pcinc4 = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset
    step(); step();
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_instr", out_instr,      32'h0);
    check("rst_out_pc",    out_pcinc4,     32'h0);
    check("rst_stall",     32'(stall_cnt), 32'h0);

    // Single entry, one-cycle latency, consumed immediately
    out_ready = 1'b1;
    drive(1'b1, 32'h0042_0013, 32'h4);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("one_valid", 32'(out_valid), 32'd1);
    check("one_instr", out_instr,      32'h0042_0013);
    check("one_pc",    out_pcinc4,     32'h4);
    step();
    check("one_drain_valid", 32'(out_valid), 32'd0);
    check("one_drain_instr", out_instr,      32'h0);

    // Fill to full, hold off C, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'h100);
    step();
    check("fill_a_valid", 32'(out_valid), 32'd1);
    check("fill_a_ready", 32'(in_ready),  32'd1);
    check("fill_a_head",  out_instr,      32'hAAAA_0001);
    drive(1'b1, 32'hBBBB_0002, 32'h104);
    step();
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_head",  out_instr,     32'hAAAA_0001);
    drive(1'b1, 32'hCCCC_0003, 32'h108);
    step();
    check("held_ready", 32'(in_ready), 32'd0);
    check("held_head",  out_instr,     32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    check("drain_b_head",  out_instr,     32'hBBBB_0002);
    check("drain_b_pc",    out_pcinc4,    32'h104);
    check("drain_b_ready", 32'(in_ready), 32'd1);
    step();
    check("drain_c_head",  out_instr,      32'hCCCC_0003);
    check("drain_c_pc",    out_pcinc4,     32'h108);
    check("drain_c_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Steady-state push+pop at count 1 across pointer wraps
    out_ready = 1'b0;
    drive(1'b1, 32'h1000_0000, 32'h4);
    step();
    check("pp_prime", out_instr, 32'h1000_0000);
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(i), 32'(4 * i + 4));
      step();
      check("pp_head",  out_instr,      32'h1000_0000 + 32'(i));
      check("pp_pc",    out_pcinc4,     32'(4 * i + 4));
      check("pp_valid", 32'(out_valid), 32'd1);
      check("pp_ready", 32'(in_ready),  32'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("pp_empty", 32'(out_valid), 32'd0);

    // Flush a full queue with same-cycle push and pop
    out_ready = 1'b0;
    drive(1'b1, 32'hE000_0001, 32'h200);
    step();
    drive(1'b1, 32'hE000_0002, 32'h204);
    step();
    check("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'hF000_0000, 32'h300);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    check("fl_instr", out_instr,      32'h0);
    check("fl_pc",    out_pcinc4,     32'h0);
    step();
    check("fl_stay_empty", 32'(out_valid), 32'd0);

    // Flush of a non-full queue also discards its same-cycle push
    out_ready = 1'b0;
    drive(1'b1, 32'hD000_0001, 32'h400);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hD000_0002, 32'h404);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl2_valid", 32'(out_valid), 32'd0);
    step();
    check("fl2_stay_empty", 32'(out_valid), 32'd0);
    drive(1'b1, 32'hD000_0003, 32'h408);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("fl2_after_head", out_instr, 32'hD000_0003);

    // Stall counter: fresh reset, then 5 stalled cycles
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h5000_0001, 32'h500);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("st_zero", 32'(stall_cnt), 32'h0);
    repeat (5) step();
`ifdef IFID_STALL_CNT_EN
    check("st_five", 32'(stall_cnt), 32'd5);
`else
    check("st_five", 32'(stall_cnt), 32'd0);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
`ifdef IFID_STALL_CNT_EN
    check("st_flush_keep", 32'(stall_cnt), 32'd6);
`else
    check("st_flush_keep", 32'(stall_cnt), 32'd0);
`endif
    drive(1'b1, 32'h5000_0002, 32'h504);
    step();
    drive(1'b0, 32'h0, 32'h0);
`ifdef IFID_STALL_CNT_EN
    force dut.u_stall_ctr.cnt_q = 16'hFFFE;
    #1;
    release dut.u_stall_ctr.cnt_q;
`endif
    repeat (3) step();
`ifdef IFID_STALL_CNT_EN
    check("st_saturate", 32'(stall_cnt), 32'h0000_FFFF);
`else
    check("st_saturate", 32'(stall_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
